gpio_cmd_sequencer: RTL and testbench

Hardware initiator for the MCU-to-fabric GPIO command protocol: turns a ready/valid command stream into the opcode/data/valid-strobe sequence that the 2D-convolution control path decodes, and reads back the returned data word and end-of-processing flag. It replaces MicroBlaze software driving in standalone builds and serves as the stimulus master in system benches. Output ports connect directly to the control path's GPIO data, control and valid inputs; its 32-bit status word returns on `i_GPIOrdata`.

---
 rtl/gpio_cmd_pkg.sv | 36 +++
 rtl/gpio_cmd_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_gpio_cmd_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_cmd_pkg.sv
// Shared definitions for the MCU-to-fabric GPIO command protocol:
// opcode values, status-word layout and the sequencer state encoding.
package gpio_cmd_pkg;

  localparam int OP_W   = 3;
  localparam int DATA_W = 24;
  localparam int RD_W   = 32;

  localparam logic [OP_W-1:0] KERNEL_LOAD  = 3'd0;
  localparam logic [OP_W-1:0] IMGSIZE_LOAD = 3'd1;
  localparam logic [OP_W-1:0] IMG_LOAD     = 3'd2;
  localparam logic [OP_W-1:0] DATA_REQUEST = 3'd3;
  localparam logic [OP_W-1:0] GO_TO_RUN    = 3'd4;

  localparam int EOP_BIT = 31;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_STROBE   = 3'd2,
    ST_HOLD_LOW = 3'd3,
    ST_READ     = 3'd4,
    ST_RUN_WAIT = 3'd5
  } seq_state_e;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op <= GO_TO_RUN;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gpio_cmd_sequencer.sv
// Drives the control path's GPIO opcode/data/valid inputs from a ready/valid
// command stream and reads back the status word for data requests and runs.
module gpio_cmd_sequencer
  import gpio_cmd_pkg::*;
#(
  parameter int SETUP_CYCLES = 2,
  parameter int HOLD_CYCLES  = 2,
  parameter int READ_WAIT    = 4,
  parameter int NB_DATA      = 13
) (
  input  logic               i_CLK,
  input  logic               i_rst,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [OP_W-1:0]    i_cmd_op,
  input  logic [DATA_W-1:0]  i_cmd_data,
  output logic [DATA_W-1:0]  o_GPIOdata,
  output logic [OP_W-1:0]    o_GPIOctrl,
  output logic               o_GPIOvalid,
  input  logic [RD_W-1:0]    i_GPIOrdata,
  output logic               o_rsp_valid,
  output logic [NB_DATA-1:0] o_rsp_data,
  output logic               o_rsp_eop,
  output logic               o_done,
  output logic               o_err,
  output logic               o_busy
);

  localparam int CNT_MAX = max3(SETUP_CYCLES, HOLD_CYCLES, READ_WAIT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  // READ is entered one cycle after the strobe falls, so it only waits READ_WAIT-1 cycles.
  localparam cnt_t SETUP_LOAD = cnt_t'(SETUP_CYCLES - 1);
  localparam cnt_t HOLD_LOAD  = cnt_t'(HOLD_CYCLES - 1);
  localparam cnt_t READ_LOAD  = cnt_t'(READ_WAIT - 2);

  seq_state_e         state_q,     state_d;
  cnt_t               cnt_q,       cnt_d;
  logic [OP_W-1:0]    ctrl_q,      ctrl_d;
  logic [DATA_W-1:0]  data_q,      data_d;
  logic               valid_q,     valid_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [NB_DATA-1:0] rsp_data_q,  rsp_data_d;
  logic               rsp_eop_q,   rsp_eop_d;
  logic               done_q,      done_d;
  logic               err_q,       err_d;

  logic cmd_fire;
  logic cnt_zero;
  logic eop_seen;
  logic unused_rdata_bits;

  assign o_cmd_ready = (state_q == ST_IDLE) && !i_rst;
  assign o_busy      = (state_q != ST_IDLE);
  assign cmd_fire    = i_cmd_valid && o_cmd_ready;
  assign cnt_zero    = (cnt_q == '0);
  assign eop_seen    = i_GPIOrdata[EOP_BIT];

  assign unused_rdata_bits = ^i_GPIOrdata[EOP_BIT-1:NB_DATA];

  always_comb begin
    // NOTE: every _d signal gets its hold value (or pulse-off value) before the case,
    // so no branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctrl_d      = ctrl_q;
    data_d      = data_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_eop_d   = rsp_eop_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (op_is_legal(i_cmd_op)) begin
            ctrl_d  = i_cmd_op;
            data_d  = i_cmd_data;
            cnt_d   = SETUP_LOAD;
            state_d = ST_SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_SETUP: begin
        if (cnt_zero) begin
          cnt_d   = HOLD_LOAD;
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end

      ST_STROBE: begin
        if (cnt_zero) begin
          state_d = ST_HOLD_LOW;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end

      ST_HOLD_LOW: begin
        case (ctrl_q)
          DATA_REQUEST: begin
            cnt_d   = READ_LOAD;
            state_d = ST_READ;
          end
          GO_TO_RUN: state_d = ST_RUN_WAIT;
          default:   state_d = ST_IDLE;
        endcase
      end

      ST_READ: begin
        if (cnt_zero) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = i_GPIOrdata[NB_DATA-1:0];
          rsp_eop_d   = eop_seen;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end

      // Parking the opcode on DATA_REQUEST stops the control path re-entering its run.
      ST_RUN_WAIT: begin
        if (eop_seen) begin
          ctrl_d  = DATA_REQUEST;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_STROBE);
  end

  always_ff @(posedge i_CLK) begin
    // NOTE: reset is synchronous and clears every register, including the held
    // response fields, so a mid-command reset aborts the strobe and leaves nothing stale.
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ctrl_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_eop_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_eop_q   <= rsp_eop_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign o_GPIOctrl  = ctrl_q;
  assign o_GPIOdata  = data_q;
  assign o_GPIOvalid = valid_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_eop   = rsp_eop_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_gpio_cmd_sequencer.sv
// Scoreboard bench for gpio_cmd_sequencer: the driver predicts strobe, read-back,
// done and error events from the protocol timing rules; a monitor matches what the DUT shows.
module tb_gpio_cmd_sequencer;

  localparam int S   = 2;
  localparam int H   = 2;
  localparam int RW  = 4;
  localparam int NBD = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [2:0]     cmd_op;
  logic [23:0]    cmd_data;
  logic [23:0]    gdata;
  logic [2:0]     gctrl;
  logic           gvalid;
  logic [31:0]    rdata;
  logic           rsp_valid;
  logic [NBD-1:0] rsp_data;
  logic           rsp_eop;
  logic           done;
  logic           err;
  logic           busy;

  gpio_cmd_sequencer #(
    .SETUP_CYCLES(S),
    .HOLD_CYCLES (H),
    .READ_WAIT   (RW),
    .NB_DATA     (NBD)
  ) dut (
    .i_CLK      (clk),
    .i_rst      (rst),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd_op   (cmd_op),
    .i_cmd_data (cmd_data),
    .o_GPIOdata (gdata),
    .o_GPIOctrl (gctrl),
    .o_GPIOvalid(gvalid),
    .i_GPIOrdata(rdata),
    .o_rsp_valid(rsp_valid),
    .o_rsp_data (rsp_data),
    .o_rsp_eop  (rsp_eop),
    .o_done     (done),
    .o_err      (err),
    .o_busy     (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int num_checks = 0;
  int num_errors = 0;

  typedef enum int {EV_STROBE, EV_RSP, EV_DONE, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int          c0;
    int          c1;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  ev_t exp_q[$];

  // Reference model: last latched opcode/payload and the cycle the sequencer is next free.
  logic [31:0] m_ctrl;
  logic [31:0] m_data;
  int          exp_ready;
  int          last_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk_ev(input ev_kind_e k, input int c0, input int c1,
                                input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    e.kind = k;
    e.c0   = c0;
    e.c1   = c1;
    e.a    = a;
    e.b    = b;
    return e;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic emit(input ev_t act);
    ev_t   e;
    string k;
    k = act.kind.name();
    if (exp_q.size() == 0) begin
      num_checks++;
      num_errors++;
      $display("FAIL unexpected_%s: got event at cycle %0d, expected no event", k, act.c0);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(act.kind), 32'(e.kind));
      check({k, "_cycle"}, act.c0, e.c0);
      check({k, "_end_cycle"}, act.c1, e.c1);
      check({k, "_a"}, act.a, e.a);
      check({k, "_b"}, act.b, e.b);
    end
  endtask

  // Monitor: samples on the falling edge and turns DUT activity into events.
  logic        mon_prev = 1'b0;
  int          mon_rise;
  logic [2:0]  mon_ctrl;
  logic [23:0] mon_data;
  logic        mon_busy;

  always @(negedge clk) begin
    if (rst) begin
      mon_prev = 1'b0;
    end else begin
      if (gvalid && !mon_prev) begin
        mon_rise = cyc;
        mon_ctrl = gctrl;
        mon_data = gdata;
        mon_busy = busy;
      end
      if (!gvalid && mon_prev) begin
        check("strobe_busy", 32'(mon_busy), 32'd1);
        emit(mk_ev(EV_STROBE, mon_rise, cyc, 32'(mon_ctrl), 32'(mon_data)));
      end
      if (rsp_valid) emit(mk_ev(EV_RSP, cyc, 0, 32'(rsp_data), 32'(rsp_eop)));
      if (done)      emit(mk_ev(EV_DONE, cyc, 0, 32'(gctrl), 32'(gdata)));
      if (err)       emit(mk_ev(EV_ERR, cyc, 0, 32'(gctrl), 32'(gdata)));
      mon_prev = gvalid;
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    rdata     = '0;
    exp_q.delete();
    m_ctrl    = '0;
    m_data    = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    check("rst_valid",     32'(gvalid),    32'd0);
    check("rst_ctrl",      32'(gctrl),     32'd0);
    check("rst_data",      32'(gdata),     32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_rsp_eop",   32'(rsp_eop),   32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_ready",     32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(cmd_ready), 32'd1);
    exp_ready = cyc;
  endtask

  // Issues one command, predicts its events, and for reads/runs also drives the status word.
  task automatic send(input logic [2:0] op, input logic [23:0] data,
                      input logic [31:0] rd, input int eop_delay);
    int v, t, n, sc, es, dn;
    v         = cyc;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    if (op == 3'd3) rdata = ~rd;
    if (op == 3'd4) rdata = '0;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!cmd_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    t      = cyc;
    last_t = t;
    check("accept_cycle", t, imax(v, exp_ready));
    sc = 0;
    es = 0;
    dn = 0;
    if (op > 3'd4) begin
      exp_q.push_back(mk_ev(EV_ERR, t + 1, 0, m_ctrl, m_data));
      exp_ready = t + 1;
    end else begin
      m_ctrl = 32'(op);
      m_data = 32'(data);
      exp_q.push_back(mk_ev(EV_STROBE, t + 1 + S, t + 1 + S + H, 32'(op), 32'(data)));
      if (op == 3'd3) begin
        sc = t + S + H + RW;
        exp_q.push_back(mk_ev(EV_RSP, sc + 1, 0, 32'(rd[NBD-1:0]), 32'(rd[31])));
        exp_ready = sc + 1;
      end else if (op == 3'd4) begin
        es = t + eop_delay;
        dn = imax(es, t + 2 + S + H) + 1;
        exp_q.push_back(mk_ev(EV_DONE, dn, 0, 32'd3, 32'(data)));
        m_ctrl    = 32'd3;
        exp_ready = dn;
        if (eop_delay == 0) rdata = 32'h8000_0000;
      end else begin
        exp_ready = t + 2 + S + H;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (op == 3'd3) begin
      wait_until(sc);
      rdata = rd;
      wait_until(sc + 1);
      rdata = ~rd;
    end else if (op == 3'd4) begin
      wait_until(es);
      rdata = 32'h8000_0000 | ($urandom() & 32'h7fff_ffff);
      wait_until(dn - 1);
      check("run_ctrl_held", 32'(gctrl), 32'd4);
      wait_until(dn);
      rdata = '0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int          r, dly;
    logic [2:0]  op;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_data  = '0;
    rdata     = '0;
    exp_ready = 0;
    last_t    = 0;

    do_reset(3);

    send(3'd0, 24'h123456, 32'd0, 0);
    send(3'd1, 24'h000200, 32'd0, 0);
    send(3'd2, 24'h0000AB, 32'd0, 0);
    send(3'd3, 24'h000000, 32'h0000_1ABC, 0);
    send(3'd3, 24'h000011, 32'h8000_0F0F, 0);
    send(3'd4, 24'h000042, 32'd0, 50);
    send(3'd6, 24'hFFFFFF, 32'd0, 0);
    send(3'd4, 24'h000777, 32'd0, 0);
    send(3'd7, 24'h00BEEF, 32'd0, 0);

    send(3'd0, 24'hC0FFEE, 32'd0, 0);
    wait_until(last_t + 1 + S);
    check("strobe_before_rst", 32'(gvalid), 32'd1);
    do_reset(1);
    repeat (8) begin
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 80; i++) begin
      r   = $urandom_range(0, 10);
      op  = (r < 8) ? 3'(r) : ((r == 8) ? 3'd3 : 3'd4);
      dly = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      send(op, 24'($urandom()), $urandom(), dly);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end

    wait_until(exp_ready + 6);
    check("pending_events", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", num_checks, num_errors);
    $finish;
  end

endmodule
